// File: rtl/mux7_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux7_rr_scheduler
//   Round-robin owner scheduler for a shared 7-to-1 one-bit mux channel.
//   One requester at a time owns the channel for at most HOLD_CYCLES cycles.
//   After each tenure the channel sits idle for GAP_CYCLES cycles, then one
//   arbitration (IDLE) cycle follows before the next tenure.
//
// Parameters
//   HOLD_CYCLES  max cycles per tenure (1..255)
//   GAP_CYCLES   idle cycles between tenures (1..15)
//
// Build option
//   MUX_SCHED_LOCK_EN  when defined, adds the lock port. While lock=1 and
//                      the owner keeps requesting, the tenure is extended.
//
// Ports
//   clock     in   1  system clock, rising edge
//   resetn    in   1  synchronous active-low reset
//   enable    in   1  scheduler run enable
//   req       in   7  per-source request, bit i <-> mux input i
//   data_in   in   7  per-source data bits (mux inputs)
//   lock      in   1  extend current tenure (MUX_SCHED_LOCK_EN only)
//   sel       out  3  registered mux select, 3'b111 = no owner
//   grant     out  7  registered one-hot grant, 0 = no owner
//   data_out  out  1  data_in[sel], 0 when there is no owner
//   busy      out  1  high while a tenure is active
// ---------------------------------------------------------------------------
module mux7_rr_scheduler #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic [6:0] req,
  input  logic [6:0] data_in,
`ifdef MUX_SCHED_LOCK_EN
  input  logic       lock,
`endif
  output logic [2:0] sel,
  output logic [6:0] grant,
  output logic       data_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [2:0] SEL_NONE  = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic [2:0] sel_q, sel_d;
  logic [6:0] grant_q, grant_d;
  logic       busy_q, busy_d;

  logic       win_valid;
  logic [2:0] win_idx;
  logic [3:0] cand;
  logic       owner_req;
  logic       hold_ext;

  // Rotating priority search: ptr, ptr+1, ... wrapping past 6 back to 0.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      cand = 4'(ptr_q) + 4'(i);
      if (cand >= 4'd7) cand = cand - 4'd7;
      if (!win_valid && req[cand[2:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  assign owner_req = |(req & (7'b1 << idx_q));

`ifdef MUX_SCHED_LOCK_EN
  assign hold_ext = lock & owner_req;
`else
  assign hold_ext = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      sel_q   <= SEL_NONE;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && win_valid) begin
          state_d = S_GRANT;
          idx_d   = win_idx;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (!owner_req || !enable || (cnt_q == HOLD_LAST && !hold_ext)) begin
          state_d = S_GAP;
          ptr_d   = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
          gap_d   = '0;
        end else if (cnt_q != HOLD_LAST) begin
          // Under lock the counter parks at HOLD_LAST instead of wrapping.
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so sel/grant/busy come straight from flops
  always_comb begin
    sel_d   = SEL_NONE;
    grant_d = '0;
    busy_d  = 1'b0;
    if (state_d == S_GRANT) begin
      sel_d   = idx_d;
      grant_d = 7'b1 << idx_d;
      busy_d  = 1'b1;
    end
  end

  always_comb begin
    data_out = 1'b0;
    case (sel_q)
      3'd0:    data_out = data_in[0];
      3'd1:    data_out = data_in[1];
      3'd2:    data_out = data_in[2];
      3'd3:    data_out = data_in[3];
      3'd4:    data_out = data_in[4];
      3'd5:    data_out = data_in[5];
      3'd6:    data_out = data_in[6];
      default: data_out = 1'b0;
    endcase
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux7_rr_scheduler.sv
module tb_mux7_rr_scheduler;

  localparam int HOLD = 4;
  localparam int GAP  = 1;
`ifdef MUX_SCHED_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clock   = 1'b0;
  logic       resetn  = 1'b0;
  logic       enable  = 1'b0;
  logic       lock    = 1'b0;
  logic [6:0] req     = '0;
  logic [6:0] data_in = '0;
  logic [2:0] sel;
  logic [6:0] grant;
  logic       data_out;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 = none), cycles owned so far,
  // remaining gap cycles, and the source that has first priority next.
  int m_owner = -1;
  int m_age   = 0;
  int m_gap   = 0;
  int m_ptr   = 0;

  always #5 clock = ~clock;

  mux7_rr_scheduler #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (enable),
    .req     (req),
    .data_in (data_in),
`ifdef MUX_SCHED_LOCK_EN
    .lock    (lock),
`endif
    .sel     (sel),
    .grant   (grant),
    .data_out(data_out),
    .busy    (busy)
  );

  function automatic void model_step();
    if (!resetn) begin
      m_owner = -1; m_age = 0; m_gap = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || !enable ||
          (m_age >= HOLD && !(LOCK_EN && lock && req[m_owner]))) begin
        m_ptr   = (m_owner + 1) % 7;
        m_owner = -1;
        m_gap   = GAP;
      end else begin
        m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (enable && req != 7'd0) begin
      for (int i = 0; i < 7; i++) begin
        if (req[(m_ptr + i) % 7]) begin
          m_owner = (m_ptr + i) % 7;
          break;
        end
      end
      m_age = 1;
    end
  endfunction

  function automatic logic [2:0] exp_sel();
    return (m_owner < 0) ? 3'd7 : 3'(m_owner);
  endfunction
  function automatic logic [6:0] exp_grant();
    return (m_owner < 0) ? 7'd0 : (7'd1 << m_owner);
  endfunction
  function automatic logic exp_busy();
    return (m_owner >= 0);
  endfunction
  function automatic logic exp_dout();
    return (m_owner < 0) ? 1'b0 : data_in[m_owner];
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic restart();
    resetn = 1'b0; enable = 1'b0; req = '0; lock = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    enable  = 1'b1;
    req     = 7'($urandom);
    data_in = 7'($urandom);
    tick();
    tick();
    n_checks++; if (sel !== 3'd7) begin n_fail++; $display("FAIL reset_sel: got %0d expected 7", sel); end
    n_checks++; if (grant !== 7'd0) begin n_fail++; $display("FAIL reset_grant: got %h expected 00", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_out: got %b expected 0", data_out); end
  endtask

  task automatic test_alternate();
    logic [6:0] tbl [14];
    tbl = '{7'h01, 7'h01, 7'h01, 7'h01, 7'h00, 7'h00, 7'h04,
            7'h04, 7'h04, 7'h04, 7'h00, 7'h00, 7'h01, 7'h01};
    restart();
    enable = 1'b1;
    req    = 7'b0000101;
    for (int c = 0; c < 14; c++) begin
      tick();
      n_checks++;
      if (grant !== tbl[c]) begin
        n_fail++; $display("FAIL alternate_trace[%0d]: got %h expected %h", c, grant, tbl[c]);
      end
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      n_checks++;
      if (sel !== exp_sel() || busy !== exp_busy()) begin
        n_fail++; $display("FAIL alternate_model[%0d]: sel %0d busy %b expected sel %0d busy %b",
                           c, sel, busy, exp_sel(), exp_busy());
      end
    end
  endtask

  task automatic test_wrap();
    logic [6:0] seen[$];
    logic [6:0] prev;
    restart();
    enable = 1'b1;
    req    = 7'b1000001;
    for (int c = 0; c < 40 && seen.size() < 3; c++) begin
      prev = grant;
      tick();
      if (grant != 7'd0 && prev == 7'd0) seen.push_back(grant);
    end
    n_checks++;
    if (seen.size() != 3) begin
      n_fail++; $display("FAIL wrap_count: got %0d tenures expected 3", seen.size());
    end else begin
      n_checks++;
      if (seen[0] !== 7'h01 || seen[1] !== 7'h40 || seen[2] !== 7'h01) begin
        n_fail++; $display("FAIL wrap_order: got %h %h %h expected 01 40 01", seen[0], seen[1], seen[2]);
      end
    end
  endtask

  task automatic test_drop();
    restart();
    enable = 1'b1;
    req    = 7'b0001000;
    tick();
    tick();
    n_checks++; if (grant !== 7'h08) begin n_fail++; $display("FAIL drop_owned: got %h expected 08", grant); end
    req = 7'b0000000;
    tick();
    n_checks++; if (grant !== 7'h00 || busy !== 1'b0 || sel !== 3'd7) begin
      n_fail++; $display("FAIL drop_release: grant %h busy %b sel %0d expected 00 0 7", grant, busy, sel);
    end
    req = 7'b0001000;
    tick();
    n_checks++; if (grant !== 7'h00) begin n_fail++; $display("FAIL drop_idle: got %h expected 00", grant); end
    tick();
    n_checks++; if (grant !== 7'h08) begin n_fail++; $display("FAIL drop_regrant: got %h expected 08", grant); end
  endtask

  task automatic test_data();
    restart();
    enable  = 1'b1;
    data_in = 7'b0101010;
    req     = 7'b0000110;
    tick();
    n_checks++; if (sel !== 3'd1 || data_out !== 1'b1) begin
      n_fail++; $display("FAIL data_src1: sel %0d data_out %b expected 1 1", sel, data_out);
    end
    for (int c = 0; c < HOLD; c++) tick();
    n_checks++; if (data_out !== 1'b0 || sel !== 3'd7) begin
      n_fail++; $display("FAIL data_gap: sel %0d data_out %b expected 7 0", sel, data_out);
    end
    tick();
    tick();
    n_checks++; if (sel !== 3'd2 || data_out !== 1'b0) begin
      n_fail++; $display("FAIL data_src2: sel %0d data_out %b expected 2 0", sel, data_out);
    end
    data_in = 7'b0000100;
    #1;
    n_checks++; if (data_out !== 1'b1) begin
      n_fail++; $display("FAIL data_comb: got %b expected 1", data_out);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    enable = 1'b1;
    req    = 7'b0010000;
    tick();
    tick();
    n_checks++; if (grant !== 7'h10) begin n_fail++; $display("FAIL midreset_owned: got %h expected 10", grant); end
    resetn = 1'b0;
    tick();
    n_checks++; if (grant !== 7'h00 || sel !== 3'd7 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: grant %h sel %0d busy %b expected 00 7 0", grant, sel, busy);
    end
    resetn = 1'b1;
    req    = 7'b1111111;
    tick();
    n_checks++; if (grant !== 7'h01) begin n_fail++; $display("FAIL midreset_ptr: got %h expected 01", grant); end
  endtask

`ifdef MUX_SCHED_LOCK_EN
  task automatic test_lock();
    restart();
    enable = 1'b1;
    lock   = 1'b1;
    req    = 7'b0000001;
    tick();
    for (int c = 1; c < HOLD + 10; c++) begin
      tick();
      n_checks++;
      if (grant !== 7'h01) begin n_fail++; $display("FAIL lock_hold[%0d]: got %h expected 01", c, grant); end
    end
    lock = 1'b0;
    tick();
    n_checks++; if (grant !== 7'h00) begin n_fail++; $display("FAIL lock_release: got %h expected 00", grant); end
  endtask
`endif

  task automatic test_random();
    restart();
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) req = 7'($urandom);
      data_in = 7'($urandom);
      enable  = ($urandom_range(0, 19) != 0);
      resetn  = ($urandom_range(0, 149) != 0);
      lock    = LOCK_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n_checks++;
      if (sel !== exp_sel() || grant !== exp_grant() || busy !== exp_busy() || data_out !== exp_dout()) begin
        n_fail++;
        $display("FAIL random[%0d]: sel %0d grant %h busy %b dout %b expected %0d %h %b %b",
                 c, sel, grant, busy, data_out, exp_sel(), exp_grant(), exp_busy(), exp_dout());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alternate();
    test_wrap();
    test_drop();
    test_data();
    test_reset_mid();
`ifdef MUX_SCHED_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
